uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8N1 receiver. Adds a 2-FF input synchroniser,
//  mid-bit start validation with glitch rejection, configurable data/stop bits, framing and overrun
//  detection, and a valid/ready output handshake. Sits between the rx pad and the command/FIFO logic.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per bit (50 MHz / 9600); must be >= 4
//  DATA_BITS     8     data bits per frame, 5..9, LSB first
//  STOP_BITS     1     stop bits checked, 1 or 2
//  PARITY_ODD    0     0 = even, 1 = odd; used only when UART_RX_PARITY_EN is defined
// PORTS
//  clk         in   1          system clock
//  rst         in   1          synchronous, active-high reset
//  rx          in   1          asynchronous serial input; idle high
//  rx_data     out  DATA_BITS  received word; stable while rx_valid=1
//  rx_valid    out  1          word available; held until accepted
//  rx_ready    in   1          consumer accepts word when rx_valid & rx_ready
//  frame_err   out  1          1-cycle pulse: a stop bit sampled low
//  parity_err  out  1          1-cycle pulse: parity mismatch (0 when parity compiled out)
//  overrun     out  1          1-cycle pulse: word completed while previous word not accepted
//  busy        out  1          high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, rx_data 0, state IDLE, sync flops 1, counters 0. Reset mid-frame aborts
//    the frame immediately; no error or valid pulse is produced for it.
//  - rx passes through two flops (rx_s); all decisions use rx_s. Add 2 cycles of input latency.
//  - Counter width $clog2(CLKS_PER_BIT); reload to CLKS_PER_BIT-1, act when it reaches 0.
//  - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; plus WAIT_IDLE.
//    IDLE: rx_s==0 -> START, counter = CLKS_PER_BIT/2-1.
//    START: at counter 0 sample rx_s; 1 -> glitch, back to IDLE (no pulse); 0 -> DATA.
//    DATA: each CLKS_PER_BIT, shift in rx_s LSB-first; after DATA_BITS samples -> PARITY or STOP.
//    PARITY: sample one bit; check against XOR of data (^PARITY_ODD).
//    STOP: sample STOP_BITS bits, each CLKS_PER_BIT apart. Any low stop bit -> frame_err pulse,
//      word discarded (no rx_valid, no parity_err), -> WAIT_IDLE. All high -> deliver, -> IDLE.
//    WAIT_IDLE: stay until rx_s==1 (break/line-low protection), then IDLE.
//  - Delivery happens in the cycle after the last stop-bit sample: if rx_valid==0 or a handshake
//    occurs that same cycle, load rx_data, rx_valid=1. If rx_valid==1 and rx_ready==0: keep old
//    word, drop new word, pulse overrun.
//  - parity_err pulses in the delivery cycle; the word is still delivered (consumer decides).
//  - rx_valid deasserts the cycle after rx_valid & rx_ready unless a new word loads that cycle.
//  - A new start bit is accepted in the first IDLE cycle; back-to-back frames need no idle gap.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present, frame = start+DATA_BITS+parity+STOP_BITS,
//    parity_err active, PARITY_ODD selects sense.
//  Not defined: no PARITY state, frame = start+DATA_BITS+STOP_BITS, parity_err tied 0,
//    PARITY_ODD ignored.
// TESTING (bench uses CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated)
//  1 Send 0xA5 8N1, rx_ready=1 -> rx_valid pulses with rx_data=0xA5, no error pulses, busy low after.
//  2 Low glitch of 6 cycles on idle rx -> returns to IDLE, no rx_valid/frame_err, busy drops by cycle ~11.
//  3 Send 0x3C with stop bit 0, rx then held low 40 cycles -> frame_err one pulse, no rx_valid,
//    busy stays high until rx returns high.
//  4 rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once; then rx_ready=1
//    -> 0x11 accepted, rx_valid drops next cycle.
//  5 UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity 1 -> ok; parity 0 -> parity_err pulse,
//    rx_data=0x07 delivered.
//  6 Assert rst for 1 cycle during DATA bit 4 of 0xFF -> all outputs 0, next clean frame 0x5A received.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Output handshake bundle of the parametrised UART receiver: received word, valid/ready
// pair, per-frame error pulses and the busy flag.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, mid-bit start validation, N data / 1-2 stop
// bits, framing and overrun detection, valid/ready output. Parity checking via UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    uart_rx_param_if.master   bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx_param: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_po
        $error("uart_rx_param: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 stop_bad;
    logic [DATA_BITS-1:0] shreg;
    logic                 deliver_pend;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;
    logic                 busy_q;

`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    wire tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            // Synchroniser resets to the idle line level so reset release never looks like a start bit.
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            cnt          <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            stop_bad     <= 1'b0;
            shreg        <= '0;
            deliver_pend <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking everywhere here, so every branch reads the pre-edge value of each flop.
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            frame_err_q <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Delivery slot: the cycle after the final stop-bit sample.
            if (deliver_pend) begin
                deliver_pend <= 1'b0;
                if (!rx_valid_q || bus.rx_ready) begin
                    rx_data_q  <= shreg;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q  <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parity_err_q <= par_bad;
`endif
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (!tick) begin
                cnt <= cnt - 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= CNT_HALF;
                        busy_q <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= DATA;
                            cnt     <= CNT_FULL;
                            bit_cnt <= '0;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt     <= CNT_FULL;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            stop_cnt <= 1'b0;
                            stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state    <= PARITY;
`else
                            state    <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bad <= ((^shreg) ^ 1'(PARITY_ODD)) != rx_s;
                        cnt     <= CNT_FULL;
                        state   <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        cnt <= CNT_FULL;
                        if (stop_cnt == STOP_LAST) begin
                            if (stop_bad || !rx_s) begin
                                frame_err_q <= 1'b1;
                                state       <= WAIT_IDLE;
                            end else begin
                                deliver_pend <= 1'b1;
                                state        <= IDLE;
                                busy_q       <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                            stop_bad <= stop_bad | ~rx_s;
                        end
                    end
                end

                WAIT_IDLE: begin
                    // Hold off while the line stays low (break) so a long low is not read as a new start bit.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = busy_q;

endmodule
